// File: rtl/divf32_pkg.sv
// Shared types and constants for the sequential single-precision divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package divf32_pkg;

    // Quotient bits produced: 24 significant plus one normalization bit.
    localparam int ITER = 25;
    // IEEE-754 single-precision exponent bias.
    localparam int BIAS = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] INF  = 32'h7F80_0000;

    // Final DIV iteration index.
    localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Operand class. Denormals are flushed to zero, so a zero exponent
    // alone means zero.
    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } fclass_t;

    function automatic fclass_t classify(input logic [31:0] x);
        fclass_t c;
        c.is_zero = (x[30:23] == 8'h00);
        c.is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        c.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        return c;
    endfunction

endpackage

// File: rtl/divf32_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
// Latency: combinational, zero cycles.
// Backpressure: none; evaluated every cycle, the caller decides when to use it.
module divf32_step (
    input  logic [24:0] i_rem,
    input  logic [23:0] i_mb,
    output logic        o_qbit,
    output logic [24:0] o_rem
);

    logic [24:0] w_mb_ext;
    logic [24:0] w_diff;

    // Partial remainder stays below 2*mb, so the shifted value fits 25 bits.
    always_comb begin
        w_mb_ext = {1'b0, i_mb};
        w_diff   = i_rem - w_mb_ext;
        o_qbit   = (i_rem >= w_mb_ext);
        o_rem    = (o_qbit ? w_diff : i_rem) << 1;
    end

endmodule

// File: rtl/divf32_seq.sv
// Sequential IEEE-754 single divider: specials, 25-step restoring divide, pack.
// Latency: 27 cycles start-to-done on the normal path, 1 cycle for specials.
// Backpressure: none; start is only sampled in IDLE, otherwise dropped.
module divf32_seq
    import divf32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] div,
    output logic        dz,
    output logic        inv
);

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_sign;
    logic [7:0]    r_ea;
    logic [7:0]    r_eb;
    logic [23:0]   r_mb;
    logic [24:0]   r_rem;
    logic [24:0]   r_q;
    logic [4:0]    r_cnt;
    logic [31:0]   r_div;
    logic          r_dz;
    logic          r_inv;

    fclass_t       w_ca;
    fclass_t       w_cb;
    logic          w_sign_in;
    logic          w_special;
    logic [31:0]   w_spec_div;
    logic          w_spec_dz;
    logic          w_spec_inv;

    logic          w_qbit;
    logic [24:0]   w_rem_nxt;

    logic signed [9:0] w_exp_raw;
    logic signed [9:0] w_exp;
    logic [22:0]   w_mant;
    logic [31:0]   w_norm_div;

    // Shared restoring step, reused once per DIV cycle.
    divf32_step u_step (
        .i_rem  (r_rem),
        .i_mb   (r_mb),
        .o_qbit (w_qbit),
        .o_rem  (w_rem_nxt)
    );

    // Special-operand detection on the live inputs, in priority order.
    always_comb begin
        w_ca       = classify(a);
        w_cb       = classify(b);
        w_sign_in  = a[31] ^ b[31];
        w_special  = 1'b1;
        w_spec_div = 32'h0000_0000;
        w_spec_dz  = 1'b0;
        w_spec_inv = 1'b0;
        if (w_ca.is_nan || w_cb.is_nan ||
            (w_ca.is_zero && w_cb.is_zero) ||
            (w_ca.is_inf && w_cb.is_inf)) begin
            w_spec_div = QNAN;
            w_spec_inv = 1'b1;
        end else if (w_cb.is_zero && !w_ca.is_inf) begin
            // finite / zero; inf / zero is an ordinary infinite result
            w_spec_div = {w_sign_in, INF[30:0]};
            w_spec_dz  = 1'b1;
        end else if (w_ca.is_inf) begin
            w_spec_div = {w_sign_in, INF[30:0]};
        end else if (w_ca.is_zero || w_cb.is_inf) begin
            w_spec_div = {w_sign_in, 31'd0};
        end else begin
            w_special  = 1'b0;
        end
    end

    // Exponent/mantissa normalization and packing with truncation.
    always_comb begin
        w_exp_raw = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb})
                  + $signed(10'(BIAS));
        if (r_q[24]) begin
            w_exp  = w_exp_raw;
            w_mant = r_q[23:1];
        end else begin
            w_exp  = w_exp_raw - 10'sd1;
            w_mant = r_q[22:0];
        end
        if (w_exp >= 10'sd255) begin
            w_norm_div = {r_sign, INF[30:0]};
        end else if (w_exp <= 10'sd0) begin
            w_norm_div = {r_sign, 31'd0};
        end else begin
            w_norm_div = {r_sign, w_exp[7:0], w_mant};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != ST_IDLE);
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = w_special ? ST_DONE : ST_DIV;
                end
            end
            ST_DIV: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = ST_NORM;
                end
            end
            ST_NORM: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand latching, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign <= 1'b0;
            r_ea   <= 8'd0;
            r_eb   <= 8'd0;
            r_mb   <= 24'd0;
            r_rem  <= 25'd0;
            r_q    <= 25'd0;
            r_cnt  <= 5'd0;
            r_div  <= 32'd0;
            r_dz   <= 1'b0;
            r_inv  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sign <= w_sign_in;
                        r_ea   <= a[30:23];
                        r_eb   <= b[30:23];
                        r_mb   <= {1'b1, b[22:0]};
                        r_rem  <= {2'b01, a[22:0]};
                        r_q    <= 25'd0;
                        r_cnt  <= 5'd0;
                        if (w_special) begin
                            r_div <= w_spec_div;
                            r_dz  <= w_spec_dz;
                            r_inv <= w_spec_inv;
                        end
                    end
                end
                ST_DIV: begin
                    // Shifting in MSB-first lands bit k at q[24-k] after 25 steps.
                    r_rem <= w_rem_nxt;
                    r_q   <= {r_q[23:0], w_qbit};
                    r_cnt <= r_cnt + 5'd1;
                end
                ST_NORM: begin
                    r_div <= w_norm_div;
                    r_dz  <= 1'b0;
                    r_inv <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign div = r_div;
    assign dz  = r_dz;
    assign inv = r_inv;

endmodule

// File: tb/tb_divf32_seq.sv
// Bench for divf32_seq: directed vectors plus random operands vs a reference.
// Latency: checks 27-cycle normal and 1-cycle special completion.
// Backpressure: exercises ignored starts while busy and in DONE.
module tb_divf32_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] div;
    logic        dz;
    logic        inv;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] prev_div = 32'd0;

    divf32_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div   (div),
        .dz    (dz),
        .inv   (inv)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    endtask

    // Reference: returns {special, inv, dz, div} using integer division.
    function automatic logic [34:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        logic [7:0]      ex, ey;
        logic [22:0]     fx, fy, mant;
        logic            s, xz, yz, xi, yi, xn, yn;
        longint unsigned num, den, q;
        int              e;
        ex = x[30:23]; ey = y[30:23]; fx = x[22:0]; fy = y[22:0];
        s  = x[31] ^ y[31];
        xz = (ex == 0); yz = (ey == 0);
        xi = (ex == 255) && (fx == 0); yi = (ey == 255) && (fy == 0);
        xn = (ex == 255) && (fx != 0); yn = (ey == 255) && (fy != 0);
        if (xn || yn || (xz && yz) || (xi && yi)) return {3'b110, 32'h7FC00000};
        if (yz && !xi) return {3'b101, s, 31'h7F800000};
        if (xi)        return {3'b100, s, 31'h7F800000};
        if (xz || yi)  return {3'b100, s, 31'h0};
        num = longint'({1'b1, fx});
        num = num << 24;
        den = longint'({1'b1, fy});
        q   = num / den;
        e   = int'(ex) - int'(ey) + 127;
        if (q >= 64'd16777216) begin
            mant = 23'(q >> 1);
        end else begin
            mant = 23'(q);
            e    = e - 1;
        end
        if (e >= 255)     return {3'b000, s, 31'h7F800000};
        else if (e <= 0)  return {3'b000, s, 31'h0};
        return {3'b000, s, 8'(e), mant};
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 9))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return 32'h7F800000;
            3: return 32'h7FC00000;
            4: return 32'h00000123;
            default: return $urandom;
        endcase
    endfunction

    // Start one operation in the first cycle after the caller's cycle.
    task automatic launch(input logic [31:0] x, input logic [31:0] y);
        @(posedge clk); #1;
        check("idle_busy", {31'd0, busy}, 32'd0);
        start = 1'b1; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    // Run one op, optionally pulsing start again at cycle T+inject.
    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input int inject);
        logic [34:0] r;
        int          n;
        logic        busy_ok;
        r = ref_div(x, y);
        launch(x, y);
        n = 1; busy_ok = 1'b1;
        while (!done && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (n == 3) check("hold", div, prev_div);
            if (n == inject) begin
                start = 1'b1; a = 32'h3F800000; b = 32'h40400000;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        if (!busy) busy_ok = 1'b0;
        check("latency", n, r[34] ? 32'd1 : 32'd27);
        check("busy_during", {31'd0, busy_ok}, 32'd1);
        check("div", div, r[31:0]);
        check("dz", {31'd0, dz}, {31'd0, r[32]});
        check("inv", {31'd0, inv}, {31'd0, r[33]});
        prev_div = r[31:0];
    endtask

    initial begin
        int dcount;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_div", div, 32'd0);
        check("rst_dz", {31'd0, dz}, 32'd0);
        check("rst_inv", {31'd0, inv}, 32'd0);
        rst = 1'b0;

        do_op(32'h40C00000, 32'h40000000, 5);
        check("6div2", div, 32'h40400000);
        do_op(32'h3F800000, 32'h40400000, 0);
        check("1div3", div, 32'h3EAAAAAA);
        do_op(32'hBFC00000, 32'h3F000000, 0);
        check("m15div05", div, 32'hC0400000);
        do_op(32'h3F800000, 32'h00000000, 0);
        check("1div0", div, 32'h7F800000);
        check("1div0_dz", {31'd0, dz}, 32'd1);
        // start held through the DONE cycle must not be taken there
        start = 1'b1; a = 32'h40C00000; b = 32'h40000000;
        do_op(32'h00000000, 32'h00000000, 0);
        check("0div0", div, 32'h7FC00000);
        check("0div0_inv", {31'd0, inv}, 32'd1);
        do_op(32'h3F800000, 32'h7F800000, 0);
        check("xdivinf", div, 32'h00000000);
        do_op(32'h00800000, 32'h7F000000, 0);
        check("underflow", div, 32'h00000000);
        do_op(32'h7F000000, 32'h00800000, 0);
        check("overflow", div, 32'h7F800000);

        // Abort mid-operation with reset at T+10.
        launch(32'h40C00000, 32'h40000000);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_div", div, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        dcount = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("abort_no_done", dcount, 32'd0);
        prev_div = 32'd0;

        for (int i = 0; i < 40; i++) begin
            do_op(rand_op(), rand_op(), (i % 4 == 0) ? 6 : 0);
        end
        for (int i = 0; i < 20; i++) begin
            logic [31:0] x, y;
            x = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
            y = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
            do_op(x, y, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
